dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive denied B cycles before B is forced (fairness build only).
REQ-002 Parameter ADDR_W, default 32: address width; data width fixed at 32.
REQ-003 CLK  input  1  sole clock, rising-edge.
REQ-004 RESET_N  input  1  asynchronous, active-low reset.
REQ-005 A_REQ / B_REQ  input  1  access request; A = pipeline MEM stage, B = loader/DMA port.
REQ-006 A_WE / B_WE  input  1  1 = write, 0 = read.
REQ-007 A_ADDR / B_ADDR  input  ADDR_W  word address.
REQ-008 A_WDATA / B_WDATA  input  32  write data.
REQ-009 A_GNT / B_GNT  output  1  request accepted this cycle (combinational).
REQ-010 A_RVALID / B_RVALID  output  1  one-cycle response pulse, read or write.
REQ-011 A_RDATA / B_RDATA  output  32  registered read data; 0 for writes.
REQ-012 A_FAULT / B_FAULT  output  1  registered segmentation fault for the responded access.
REQ-013 MEM_ADDRESS, MEM_WRITE_DATA  output  ADDR_W, 32  to DATA_MEMORY ADDRESS, WRITE_DATA.
REQ-014 MEM_MemRead, MEM_MemWrite  output  1  to DATA_MEMORY MemRead, MemWrite.
REQ-015 MEM_READ_DATA, MEM_SEGFAULT  input  32, 1  from DATA_MEMORY READ_DATA, SEGMENTATION_FAULT_DMEM.
REQ-016 FAULT_STICKY  output  1  set by any fault, cleared only by reset.

Function
REQ-017 At most one of A_GNT/B_GNT shall be high per cycle; GNT high only when matching REQ high.
REQ-018 Default priority: A over B; B granted only when A_REQ low (or forced per REQ-029).
REQ-019 Granted port's ADDR/WDATA shall drive MEM_* combinationally the same cycle; MemRead = GNT & ~WE, MemWrite = GNT & WE.
REQ-020 No grant: MEM_MemRead = MEM_MemWrite = 0, MEM_ADDRESS/MEM_WRITE_DATA = 0.
REQ-021 Write commits at the grant-cycle rising edge (memory-side).
REQ-022 Response latency exactly 1 cycle: at the edge ending a grant, capture MEM_READ_DATA (reads) and MEM_SEGFAULT into the granted port's RDATA/FAULT and pulse its RVALID for one cycle.
REQ-023 Response FSM: IDLE, RESP_A, RESP_B; next state = RESP_A if A granted, RESP_B if B granted, else IDLE; every state may transition to any state each cycle (back-to-back grants at full throughput).
REQ-024 Non-responding port's RVALID shall be 0; RDATA/FAULT hold last captured value.
REQ-025 A_REQ and B_REQ rising in the same cycle: A granted, B waits; B_REQ must be held until B_GNT.
REQ-026 Requester dropping REQ before GNT: request withdrawn, no response.
REQ-027 FAULT_STICKY sets the cycle after any granted access with MEM_SEGFAULT = 1.

Reset
REQ-028 RESET_N low: FSM = IDLE, all RVALID/RDATA/FAULT/FAULT_STICKY = 0, starvation counter = 0, MEM_MemRead/MemWrite forced 0 and GNT forced 0 asynchronously; a response pending at reset shall be dropped (no RVALID after release).

Configuration
REQ-029 DMEM_ARB_FAIRNESS_EN defined: 3-bit+ counter increments each cycle B_REQ high and not granted, clears on B_GNT or B_REQ low; when count == STARVE_LIMIT, B granted and A_GNT held low that cycle.
REQ-030 DMEM_ARB_FAIRNESS_EN undefined: strict A priority, no counter, STARVE_LIMIT unused; B may starve indefinitely.

Verification
REQ-031 A write addr 5 data 0xDEADBEEF, then A read addr 5 -> A_GNT same cycle each, A_RVALID next cycle, A_RDATA = 0xDEADBEEF, B_RVALID = 0.
REQ-032 A_REQ and B_REQ high same cycle, reads addr 1/2 -> A_GNT cycle 0, B_GNT cycle 1, A_RVALID cycle 1, B_RVALID cycle 2.
REQ-033 Fairness build, A_REQ held high, B_REQ high, STARVE_LIMIT = 4 -> B_GNT in 5th cycle with A_GNT = 0 that cycle; undefined build -> B_GNT never.
REQ-034 B read to out-of-range addr (SEGFAULT = 1) -> B_FAULT = 1 with B_RVALID, FAULT_STICKY = 1 until RESET_N low.
REQ-035 RESET_N low for one cycle immediately after an A read grant -> no A_RVALID, all outputs 0, MEM_MemRead = 0 during reset.
REQ-036 Back-to-back A reads addr 0..127 -> 128 consecutive RVALID pulses, RDATA = prior written values.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter -- two-port arbiter in front of a single-ported DATA_MEMORY.
//
// Port A is the pipeline MEM stage and port B is the loader/DMA port.
// Grants are combinational. The granted port's address and write data are
// steered onto the memory bus in the same cycle. The response (read data,
// fault flag and a one-cycle RVALID pulse) comes back exactly one cycle later.
//
// Build option: define DMEM_ARB_FAIRNESS_EN to add a starvation counter for
// port B. When it is undefined, A has strict priority and STARVE_LIMIT has no
// effect.
//
// Ports
//   CLK, RESET_N             clock (rising edge), asynchronous active-low reset
//   A_REQ/A_WE/A_ADDR/A_WDATA     port A request, write enable, address, data
//   B_REQ/B_WE/B_ADDR/B_WDATA     port B request, write enable, address, data
//   A_GNT/B_GNT              combinational grant
//   A_RVALID/B_RVALID        one-cycle response pulse
//   A_RDATA/B_RDATA          registered read data (0 for writes)
//   A_FAULT/B_FAULT          registered segmentation fault of the response
//   MEM_ADDRESS, MEM_WRITE_DATA, MEM_MemRead, MEM_MemWrite  to DATA_MEMORY
//   MEM_READ_DATA, MEM_SEGFAULT                            from DATA_MEMORY
//   FAULT_STICKY             set by any faulting access, cleared by reset only
`timescale 1ns/1ps
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 32
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              A_REQ,
  input  logic              A_WE,
  input  logic [ADDR_W-1:0] A_ADDR,
  input  logic [31:0]       A_WDATA,
  input  logic              B_REQ,
  input  logic              B_WE,
  input  logic [ADDR_W-1:0] B_ADDR,
  input  logic [31:0]       B_WDATA,
  output logic              A_GNT,
  output logic              B_GNT,
  output logic              A_RVALID,
  output logic              B_RVALID,
  output logic [31:0]       A_RDATA,
  output logic [31:0]       B_RDATA,
  output logic              A_FAULT,
  output logic              B_FAULT,
  output logic [ADDR_W-1:0] MEM_ADDRESS,
  output logic [31:0]       MEM_WRITE_DATA,
  output logic              MEM_MemRead,
  output logic              MEM_MemWrite,
  input  logic [31:0]       MEM_READ_DATA,
  input  logic              MEM_SEGFAULT,
  output logic              FAULT_STICKY
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP_A = 2'd1,
    RESP_B = 2'd2
  } resp_state_e;

  resp_state_e state_q, state_d;

  logic        a_gnt, b_gnt;
  logic        force_b;
  logic [31:0] a_rdata_q, b_rdata_q;
  logic        a_fault_q, b_fault_q;
  logic        sticky_q;

`ifdef DMEM_ARB_FAIRNESS_EN
  // The counter is at least 3 bits wide, and wider if needed to reach STARVE_LIMIT.
  localparam int CNT_W = (STARVE_LIMIT < 8) ? 3 : $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  // B has been refused STARVE_LIMIT cycles in a row. It wins this cycle even over A.
  assign force_b = B_REQ && (starve_cnt_q == CNT_W'(STARVE_LIMIT));

  always_comb begin
    starve_cnt_d = '0;
    if (B_REQ && !b_gnt) starve_cnt_d = starve_cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) starve_cnt_q <= '0;
    else          starve_cnt_q <= starve_cnt_d;
  end
`else
  // Strict A priority. The limit is deliberately ignored in this build.
  logic unused_starve_limit;
  assign unused_starve_limit = (STARVE_LIMIT != 0);
  assign force_b = 1'b0;
`endif

  // Gating the grants with RESET_N also kills the memory strobes
  // asynchronously while reset is held.
  assign a_gnt = RESET_N && A_REQ && !force_b;
  assign b_gnt = RESET_N && B_REQ && (!A_REQ || force_b);
  assign A_GNT = a_gnt;
  assign B_GNT = b_gnt;

  // Memory bus mux. The bus is all-zero when no port holds a grant.
  always_comb begin
    MEM_ADDRESS    = '0;
    MEM_WRITE_DATA = '0;
    MEM_MemRead    = 1'b0;
    MEM_MemWrite   = 1'b0;
    if (a_gnt) begin
      MEM_ADDRESS    = A_ADDR;
      MEM_WRITE_DATA = A_WDATA;
      MEM_MemRead    = !A_WE;
      MEM_MemWrite   = A_WE;
    end else if (b_gnt) begin
      MEM_ADDRESS    = B_ADDR;
      MEM_WRITE_DATA = B_WDATA;
      MEM_MemRead    = !B_WE;
      MEM_MemWrite   = B_WE;
    end
  end

  // Response FSM. Any state may go to any state, so grants can run back to back.
  always_comb begin
    state_d  = IDLE;
    A_RVALID = 1'b0;
    B_RVALID = 1'b0;
    if (a_gnt)      state_d = RESP_A;
    else if (b_gnt) state_d = RESP_B;
    case (state_q)
      RESP_A:  A_RVALID = 1'b1;
      RESP_B:  B_RVALID = 1'b1;
      default: ;
    endcase
  end

  // Capture the response at the edge that ends the grant. Data and fault
  // belong to the port that was granted. The other port keeps its old values.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      a_fault_q <= 1'b0;
      b_fault_q <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (a_gnt) begin
        a_rdata_q <= A_WE ? 32'h0 : MEM_READ_DATA;
        a_fault_q <= MEM_SEGFAULT;
      end
      if (b_gnt) begin
        b_rdata_q <= B_WE ? 32'h0 : MEM_READ_DATA;
        b_fault_q <= MEM_SEGFAULT;
      end
      if ((a_gnt || b_gnt) && MEM_SEGFAULT) sticky_q <= 1'b1;
    end
  end

  assign A_RDATA      = a_rdata_q;
  assign B_RDATA      = b_rdata_q;
  assign A_FAULT      = a_fault_q;
  assign B_FAULT      = b_fault_q;
  assign FAULT_STICKY = sticky_q;

endmodule
